// File: rtl/clock_div_pkg.sv
// Shared definitions for the slow-clock divider timebase.
package clock_div_pkg;

    localparam int unsigned COUNT_WIDTH  = 14;
    localparam int unsigned DEFAULT_HALF = 4999;        // 10 MHz -> 1 kHz
    localparam int unsigned BOARD_CLK_HZ = 10_000_000;

    typedef enum logic [1:0] {
        StStopped,
        StRunning,
        StStopping
    } divState_t;

endpackage

// File: rtl/half_period_counter.sv
// Half-period counter: counts 0..limit, flags the last cycle as the boundary.
module half_period_counter #(
    parameter int unsigned WIDTH = clock_div_pkg::COUNT_WIDTH
) (
    input  logic             inClock,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             boundary
);

    assign boundary = enable && (count == limit);

    // Count up while enabled, wrapping to zero on the boundary cycle
    always_ff @(posedge inClock) begin
        if (clear) begin
            count <= '0;
        end else if (boundary) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/clock_divider_ctrl.sv
// Run-time controller for the divided square-wave timebase: start/stop FSM,
// ratio handshake and the registered outClock/tick outputs.
module clock_divider_ctrl #(
    parameter int unsigned COUNT_WIDTH  = clock_div_pkg::COUNT_WIDTH,
    parameter int unsigned DEFAULT_HALF = clock_div_pkg::DEFAULT_HALF
) (
    input  logic                   inClock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   cfgValid,
    input  logic [COUNT_WIDTH-1:0] cfgHalf,
    output logic                   cfgReady,
    output logic                   outClock,
    output logic                   tick,
    output logic                   running
);

    import clock_div_pkg::*;

    divState_t              state;
    logic [COUNT_WIDTH-1:0] halfReg;
    logic [COUNT_WIDTH-1:0] pendReg;
    logic                   pendValid;
    logic [COUNT_WIDTH-1:0] count;
    logic                   boundary;
    logic                   cfgXfer;
    logic                   abortLow;
    logic                   toggle;
    logic                   goStop;
    logic                   counterClear;

    assign cfgReady = !pendValid;
    assign running  = (state != StStopped);

    half_period_counter #(
        .WIDTH (COUNT_WIDTH)
    ) uCounter (
        .inClock  (inClock),
        .clear    (counterClear),
        .enable   (running),
        .limit    (halfReg),
        .count    (count),
        .boundary (boundary)
    );

    // Decode stop conditions and whether this boundary really toggles
    always_comb begin
        cfgXfer      = cfgValid && !pendValid;
        // Disabled while low: park immediately, swallowing any boundary so no runt high
        abortLow     = (state == StRunning) && !enable && !outClock;
        toggle       = boundary && !abortLow;
        // A falling toggle with enable low ends the run in either active state
        goStop       = abortLow || (toggle && outClock && !enable);
        counterClear = reset || goStop || (state == StStopped);
    end

    // Controller FSM, config registers and registered clock outputs
    always_ff @(posedge inClock) begin
        if (reset) begin
            state     <= StStopped;
            outClock  <= 1'b0;
            tick      <= 1'b0;
            halfReg   <= COUNT_WIDTH'(DEFAULT_HALF);
            pendReg   <= '0;
            pendValid <= 1'b0;
        end else begin
            tick <= toggle;
            if (toggle) begin
                outClock <= ~outClock;
            end

            if (goStop) begin
                // Settle any outstanding ratio before parking
                if (cfgXfer) begin
                    halfReg <= cfgHalf;
                end else if (pendValid) begin
                    halfReg <= pendReg;
                end
                pendValid <= 1'b0;
            end else if (toggle && pendValid) begin
                halfReg   <= pendReg;
                pendValid <= 1'b0;
            end else if (cfgXfer) begin
                if (state == StStopped) begin
                    halfReg <= cfgHalf;
                end else begin
                    pendReg   <= cfgHalf;
                    pendValid <= 1'b1;
                end
            end

            unique case (state)
                StStopped: begin
                    if (enable) begin
                        state <= StRunning;
                    end
                end
                StRunning: begin
                    if (goStop) begin
                        state <= StStopped;
                    end else if (!enable) begin
                        state <= StStopping;
                    end
                end
                StStopping: begin
                    if (enable) begin
                        state <= StRunning;
                    end else if (goStop) begin
                        state <= StStopped;
                    end
                end
                default: state <= StStopped;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Self-checking bench for clock_divider_ctrl: expected toggle edges are queued
// when stimulus is applied and popped by a tick monitor.
module tb_clock_divider_ctrl;

    localparam int unsigned CW = 14;

    logic          inClock;
    logic          reset;
    logic          enable;
    logic          cfgValid;
    logic [CW-1:0] cfgHalf;
    logic          cfgReady;
    logic          outClock;
    logic          tick;
    logic          running;

    typedef struct {
        int   cycle;
        logic level;
    } expEdge_t;

    expEdge_t expQ[$];
    int       cyc;
    int       checkCnt;
    int       passCnt;
    int       lastToggle;

    clock_divider_ctrl #(
        .COUNT_WIDTH  (CW),
        .DEFAULT_HALF (4999)
    ) dut (
        .inClock  (inClock),
        .reset    (reset),
        .enable   (enable),
        .cfgValid (cfgValid),
        .cfgHalf  (cfgHalf),
        .cfgReady (cfgReady),
        .outClock (outClock),
        .tick     (tick),
        .running  (running)
    );

    initial begin
        inClock = 1'b0;
        forever #5 inClock = ~inClock;
    end

    // cyc holds the index of the most recent rising edge
    initial cyc = 0;
    always @(posedge inClock) cyc <= cyc + 1;

    // Every tick must match the oldest expected toggle edge and level
    always @(negedge inClock) begin
        expEdge_t e;
        if (tick === 1'b1) begin
            checkCnt++;
            if (expQ.size() == 0) begin
                $display("FAIL tick_unexpected at cycle %0d outClock %b", cyc, outClock);
            end else begin
                e = expQ.pop_front();
                if (cyc != e.cycle || outClock !== e.level)
                    $display("FAIL tick_edge got cycle %0d level %b want cycle %0d level %b",
                             cyc, outClock, e.cycle, e.level);
                else passCnt++;
            end
        end
    end

    task automatic pushExp(input int cy, input logic lv);
        expEdge_t e;
        e.cycle = cy;
        e.level = lv;
        expQ.push_back(e);
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge inClock);
    endtask

    task automatic loadStopped(input logic [CW-1:0] h);
        cfgValid = 1'b1;
        cfgHalf  = h;
        @(negedge inClock);
        cfgValid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; cfgValid = 1'b0; cfgHalf = '0;
        repeat (3) @(negedge inClock);
        reset = 1'b0;
        repeat (20) @(negedge inClock);
        checkCnt++; if (outClock !== 1'b0) $display("FAIL reset_outClock got %b want 0", outClock); else passCnt++;
        checkCnt++; if (tick !== 1'b0) $display("FAIL reset_tick got %b want 0", tick); else passCnt++;
        checkCnt++; if (running !== 1'b0) $display("FAIL reset_running got %b want 0", running); else passCnt++;
        checkCnt++; if (cfgReady !== 1'b1) $display("FAIL reset_cfgReady got %b want 1", cfgReady); else passCnt++;
    endtask

    task automatic test_default();
        int c;
        c = cyc;
        enable = 1'b1;
        for (int j = 0; j < 4; j++) pushExp(c + 5001 + 5000 * j, (j % 2 == 0));
        waitUntil(c + 1);
        checkCnt++; if (running !== 1'b1) $display("FAIL default_running got %b want 1", running); else passCnt++;
        waitUntil(c + 5000);
        checkCnt++; if (outClock !== 1'b0) $display("FAIL default_before_rise got %b want 0", outClock); else passCnt++;
        waitUntil(c + 20001);
        enable = 1'b0;
        @(negedge inClock);
        checkCnt++; if (running !== 1'b0) $display("FAIL default_stop_running got %b want 0", running); else passCnt++;
        checkCnt++; if (expQ.size() != 0) $display("FAIL default_drain got %0d left want 0", expQ.size()); else passCnt++;
    endtask

    task automatic test_cfg_stopped();
        int c;
        int drops;
        loadStopped(14'd3);
        checkCnt++; if (cfgReady !== 1'b1) $display("FAIL stopped_cfgReady got %b want 1", cfgReady); else passCnt++;
        c = cyc;
        enable = 1'b1;
        pushExp(c + 5, 1'b1); pushExp(c + 9, 1'b0); pushExp(c + 13, 1'b1); pushExp(c + 17, 1'b0);
        drops = 0;
        while (cyc < c + 17) begin
            @(negedge inClock);
            if (cfgReady !== 1'b1) drops++;
        end
        checkCnt++; if (drops != 0) $display("FAIL stopped_ready_drops got %0d want 0", drops); else passCnt++;
        lastToggle = c + 17;
    endtask

    task automatic test_reconfig();
        int t;
        t = lastToggle;
        waitUntil(t + 1);
        cfgValid = 1'b1; cfgHalf = 14'd1;
        pushExp(t + 4, 1'b1);  pushExp(t + 6, 1'b0);  pushExp(t + 8, 1'b1);  pushExp(t + 10, 1'b0);
        pushExp(t + 12, 1'b1); pushExp(t + 15, 1'b0); pushExp(t + 19, 1'b1); pushExp(t + 23, 1'b0);
        @(negedge inClock);
        cfgValid = 1'b0;
        checkCnt++; if (cfgReady !== 1'b0) $display("FAIL reconfig_pend_a got %b want 0", cfgReady); else passCnt++;
        @(negedge inClock);
        checkCnt++; if (cfgReady !== 1'b0) $display("FAIL reconfig_pend_b got %b want 0", cfgReady); else passCnt++;
        @(negedge inClock);
        checkCnt++; if (cfgReady !== 1'b1) $display("FAIL reconfig_applied got %b want 1", cfgReady); else passCnt++;
        waitUntil(t + 10);
        cfgValid = 1'b1; cfgHalf = 14'd2;
        @(negedge inClock);
        checkCnt++; if (cfgReady !== 1'b0) $display("FAIL held_first_taken got %b want 0", cfgReady); else passCnt++;
        cfgHalf = 14'd3;
        @(negedge inClock);
        checkCnt++; if (cfgReady !== 1'b1) $display("FAIL held_ready_rise got %b want 1", cfgReady); else passCnt++;
        @(negedge inClock);
        checkCnt++; if (cfgReady !== 1'b0) $display("FAIL held_second_taken got %b want 0", cfgReady); else passCnt++;
        cfgValid = 1'b0;
        waitUntil(t + 15);
        checkCnt++; if (cfgReady !== 1'b1) $display("FAIL held_second_applied got %b want 1", cfgReady); else passCnt++;
        waitUntil(t + 24);
        checkCnt++; if (expQ.size() != 0) $display("FAIL reconfig_drain got %0d left want 0", expQ.size()); else passCnt++;
        lastToggle = t + 23;
    endtask

    task automatic test_stop();
        int r;
        r = lastToggle + 4;
        pushExp(r, 1'b1);
        pushExp(r + 4, 1'b0);
        waitUntil(r);
        enable = 1'b0;
        @(negedge inClock);
        checkCnt++; if (running !== 1'b1) $display("FAIL stopping_running got %b want 1", running); else passCnt++;
        checkCnt++; if (outClock !== 1'b1) $display("FAIL stopping_high got %b want 1", outClock); else passCnt++;
        waitUntil(r + 4);
        checkCnt++; if (outClock !== 1'b0) $display("FAIL stopped_low got %b want 0", outClock); else passCnt++;
        checkCnt++; if (running !== 1'b0) $display("FAIL stopped_running got %b want 0", running); else passCnt++;
        repeat (10) @(negedge inClock);
        checkCnt++; if (expQ.size() != 0) $display("FAIL stop_drain got %0d left want 0", expQ.size()); else passCnt++;
    endtask

    task automatic test_resume();
        int c;
        c = cyc;
        enable = 1'b1;
        pushExp(c + 5, 1'b1);  pushExp(c + 9, 1'b0);  pushExp(c + 13, 1'b1);
        pushExp(c + 17, 1'b0); pushExp(c + 21, 1'b1); pushExp(c + 25, 1'b0);
        waitUntil(c + 13);
        enable = 1'b0;
        @(negedge inClock);
        checkCnt++; if (running !== 1'b1) $display("FAIL resume_stopping got %b want 1", running); else passCnt++;
        enable = 1'b1;
        @(negedge inClock);
        checkCnt++; if (running !== 1'b1) $display("FAIL resume_running got %b want 1", running); else passCnt++;
        waitUntil(c + 25);
        enable = 1'b0;
        @(negedge inClock);
        checkCnt++; if (running !== 1'b0) $display("FAIL resume_park got %b want 0", running); else passCnt++;
        checkCnt++; if (expQ.size() != 0) $display("FAIL resume_drain got %0d left want 0", expQ.size()); else passCnt++;
    endtask

    task automatic test_half_zero();
        int c;
        loadStopped(14'd0);
        c = cyc;
        enable = 1'b1;
        pushExp(c + 2, 1'b1); pushExp(c + 3, 1'b0); pushExp(c + 4, 1'b1); pushExp(c + 5, 1'b0);
        waitUntil(c + 5);
        enable = 1'b0;
        @(negedge inClock);
        checkCnt++; if (outClock !== 1'b0) $display("FAIL zero_park got %b want 0", outClock); else passCnt++;
        checkCnt++; if (tick !== 1'b0) $display("FAIL zero_no_tick got %b want 0", tick); else passCnt++;
        repeat (3) @(negedge inClock);
        checkCnt++; if (expQ.size() != 0) $display("FAIL zero_drain got %0d left want 0", expQ.size()); else passCnt++;
    endtask

    task automatic test_reset_mid();
        int c;
        int d;
        loadStopped(14'd3);
        c = cyc;
        enable = 1'b1;
        pushExp(c + 5, 1'b1);
        waitUntil(c + 6);
        cfgValid = 1'b1; cfgHalf = 14'd1;
        @(negedge inClock);
        cfgValid = 1'b0;
        checkCnt++; if (cfgReady !== 1'b0) $display("FAIL mid_pending got %b want 0", cfgReady); else passCnt++;
        reset = 1'b1; enable = 1'b0;
        @(negedge inClock);
        reset = 1'b0;
        checkCnt++; if (outClock !== 1'b0) $display("FAIL mid_outClock got %b want 0", outClock); else passCnt++;
        checkCnt++; if (tick !== 1'b0) $display("FAIL mid_tick got %b want 0", tick); else passCnt++;
        checkCnt++; if (running !== 1'b0) $display("FAIL mid_running got %b want 0", running); else passCnt++;
        checkCnt++; if (cfgReady !== 1'b1) $display("FAIL mid_cfgReady got %b want 1", cfgReady); else passCnt++;
        d = cyc;
        enable = 1'b1;
        pushExp(d + 5001, 1'b1);
        pushExp(d + 10001, 1'b0);
        waitUntil(d + 10001);
        enable = 1'b0;
        @(negedge inClock);
        checkCnt++; if (running !== 1'b0) $display("FAIL mid_final_park got %b want 0", running); else passCnt++;
        checkCnt++; if (expQ.size() != 0) $display("FAIL mid_drain got %0d left want 0", expQ.size()); else passCnt++;
    endtask

    initial begin
        checkCnt   = 0;
        passCnt    = 0;
        lastToggle = 0;
        reset      = 1'b1;
        enable     = 1'b0;
        cfgValid   = 1'b0;
        cfgHalf    = '0;
        test_reset();
        test_default();
        test_cfg_stopped();
        test_reconfig();
        test_stop();
        test_resume();
        test_half_zero();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/clock_divider_ctrl.md
# clock_divider_ctrl

Run-time controller for the square-wave divider timebase. It holds a programmable half-period, starts and stops the divided output cleanly, and accepts new ratios through a valid/ready handshake. Ratio changes take effect only at half-period boundaries, so `outClock` never produces a runt pulse. It sits between the board clock (10 MHz) and every block that consumes the slow clock or its tick.

## Interface
- `COUNT_WIDTH`, default 14: width of the half-period counter and config word.
- `DEFAULT_HALF`, default 4999: half-period reload loaded at reset. Gives 10 MHz → 1 kHz.
- `inClock` input 1: the single clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `enable` input 1: level request to run the divided output.
- `cfgValid` input 1: a new half-period value is offered.
- `cfgHalf` input COUNT_WIDTH: offered value N; half-period = N+1 `inClock` cycles.
- `cfgReady` output 1: the controller can accept a value this cycle.
- `outClock` output 1: divided square wave; registered.
- `tick` output 1: one-cycle pulse on every `outClock` toggle; registered.
- `running` output 1: high in RUNNING or STOPPING.

## Operation
- State machine states:
  - STOPPED: counter held at 0; `outClock` parked at 0.
  - RUNNING: counting and toggling.
  - STOPPING: still counting; waiting to park `outClock` low.
- Registers: `count`, `halfReg`, `pendReg`, `pendValid`, `state`.
- Transfer occurs when `cfgValid && cfgReady`.
- `cfgReady` = !`pendValid`.
  - In STOPPED, a transfer writes `halfReg` directly.
  - In RUNNING or STOPPING, a transfer writes `pendReg` and sets `pendValid`.
- Boundary = a cycle in RUNNING or STOPPING with `count == halfReg`. At a boundary:
  - `outClock` toggles and `tick` = 1.
  - `count` clears to 0.
  - If `pendValid`, then `halfReg <= pendReg` and `pendValid` clears.
  - Otherwise `count` increments and never exceeds `halfReg`.
- A transfer in the same cycle as a boundary becomes pending and applies at the *following* boundary.
- STOPPED → RUNNING when `enable` = 1. `count` starts at 0.
- RUNNING → STOPPING when `enable` = 0 and `outClock` = 1.
- RUNNING → STOPPED when `enable` = 0 and `outClock` = 0. `count` clears.
- STOPPING → RUNNING when `enable` returns to 1. `count` and `outClock` are undisturbed.
- STOPPING → STOPPED at the boundary that drives `outClock` 1→0. `tick` still pulses on that boundary.
- On entry to STOPPED with `pendValid` set, `pendReg` is copied into `halfReg`.
- `cfgHalf` = 0 is legal: `outClock` toggles every cycle.

## Timing
- Reset values:
  - `outClock` = 0, `tick` = 0, `running` = 0, `cfgReady` = 1.
  - `count` = 0, `halfReg` = DEFAULT_HALF, `pendValid` = 0, state STOPPED.
- Reset mid-operation: all of the above apply on the next edge; any pending config is discarded.
- Start latency:
  - `enable` sampled high at edge k → `running` = 1 after edge k.
  - First toggle at edge k + halfReg + 1.
- Period = 2·(halfReg+1) cycles; duty exactly 50%.
- `tick` and `outClock` change on the same edge.
- `cfgReady` falls the edge after a running-state transfer and rises the edge after the applying boundary.

## Structure
- Shared package `clock_div_pkg` holds:
  - the state enum (STOPPED, RUNNING, STOPPING);
  - `COUNT_WIDTH`;
  - `DEFAULT_HALF`;
  - `BOARD_CLK_HZ` = 10_000_000.
- One sub-module is natural: `half_period_counter`.
  - Ports: clear, enable, limit; outputs count and boundary.
- The controller FSM, config handshake and `outClock`/`tick` registers stay in the top module.

## Test plan
- Reset, then idle 20 cycles → `outClock` = 0, `tick` = 0, `running` = 0, `cfgReady` = 1.
- `enable` = 1 with default config → ticks every 5000 cycles; `outClock` period 10000 cycles; first rise 5000 cycles after start.
- In STOPPED, send `cfgHalf` = 3, then enable → `outClock` high 4 / low 4. `cfgReady` never drops.
- Running with `cfgHalf` = 3:
  - Send `cfgHalf` = 1 two cycles after a toggle → `cfgReady` = 0 until the next boundary.
  - From then the half-period is 2 cycles.
  - A second offer held on `cfgValid` transfers only once `cfgReady` rises.
- Running with `cfgHalf` = 3:
  - Drop `enable` one cycle after a rise → STOPPING; `outClock` falls 3 cycles later with `tick`; `running` = 0 the cycle after.
  - Re-enabling during STOPPING continues without a phase jump.
- Assert `reset` mid-high-phase with a pending config → next cycle all reset values apply; after re-enable the period is from DEFAULT_HALF.
